// File: rtl/sdram_aux_arbiter_if.sv
// ----------------------------------------------------------------------------
// sdram_aux_arbiter_if
//   Word-request handshake between one auxiliary SDRAM requester (flash
//   streamer, snapshot DMA, ...) and sdram_aux_arbiter.
//
//   aux_req   requester -> arbiter  level request, held with the command
//                                   fields stable until aux_ack
//   aux_we    requester -> arbiter  1 = write, 0 = read
//   aux_ds    requester -> arbiter  {UDS,LDS} byte strobes
//   aux_addr  requester -> arbiter  22-bit word address
//   aux_din   requester -> arbiter  write data
//   aux_ack   arbiter -> requester  one-cycle pulse: access completed
//   aux_dout  arbiter -> requester  read data, valid with aux_ack, held after
//   aux_err   arbiter -> requester  sticky: too many aborts on this request
//
//   master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface sdram_aux_arbiter_if;
    logic        aux_req;
    logic        aux_we;
    logic [1:0]  aux_ds;
    logic [21:0] aux_addr;
    logic [15:0] aux_din;
    logic        aux_ack;
    logic [15:0] aux_dout;
    logic        aux_err;

    modport master (
        output aux_req, aux_we, aux_ds, aux_addr, aux_din,
        input  aux_ack, aux_dout, aux_err
    );

    modport slave (
        input  aux_req, aux_we, aux_ds, aux_addr, aux_din,
        output aux_ack, aux_dout, aux_err
    );
endinterface

// File: rtl/sdram_aux_arbiter.sv
// ----------------------------------------------------------------------------
// sdram_aux_arbiter
//   Shares the single SDRAM port between the gstmcu chipset and one auxiliary
//   word requester. The chipset always wins with zero added latency: its
//   signals pass straight through to sd_* unless an aux cycle currently owns
//   the bus, and even then a chipset request takes the bus back in the same
//   cycle (the aux cycle is aborted and retried at the next free slot).
//
// Ports
//   clk32, atari_reset_n     32 MHz clock, async active-low reset
//   chip_cs/we/ds/addr/din   chipset access decoded from RAS/CAS/WE
//   chip_refresh             chipset refresh request
//   slot_free                gstmcu phase: no chipset access for AUX_LEN cycles
//   aux                      auxiliary requester handshake (slave side)
//   sd_cs/we/ds/addr/din     to sdram
//   sd_refresh               to sdram refresh
//   sd_dout                  from sdram read data
//   collisions               saturating count of aborted aux cycles
//
// Parameters
//   AUX_LEN    clk32 cycles an aux access holds the sdram (>= 3)
//   DATA_LAT   cycle index (0-based, < AUX_LEN) at which read data is sampled
//   MAX_RETRY  aborts on one request before aux_err is raised
// ----------------------------------------------------------------------------
module sdram_aux_arbiter #(
    parameter int AUX_LEN   = 6,
    parameter int DATA_LAT  = 5,
    parameter int MAX_RETRY = 15
) (
    input  logic               clk32,
    input  logic               atari_reset_n,

    input  logic               chip_cs,
    input  logic               chip_we,
    input  logic [1:0]         chip_ds,
    input  logic [21:0]        chip_addr,
    input  logic [15:0]        chip_din,
    input  logic               chip_refresh,
    input  logic               slot_free,

    sdram_aux_arbiter_if.slave aux,

    output logic               sd_cs,
    output logic               sd_we,
    output logic [1:0]         sd_ds,
    output logic [21:0]        sd_addr,
    output logic [15:0]        sd_din,
    output logic               sd_refresh,
    input  logic [15:0]        sd_dout,

    output logic [7:0]         collisions
);

    localparam int               CNT_W       = (AUX_LEN > 1) ? $clog2(AUX_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(AUX_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_DATA    = CNT_W'(DATA_LAT);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AUX,
        ST_ACK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       retry;

    // Command captured at the start of an aux cycle.
    logic             lat_we;
    logic [1:0]       lat_ds;
    logic [21:0]      lat_addr;
    logic [15:0]      lat_din;

    logic [15:0]      dout_shadow;
    logic [15:0]      dout_q;
    logic             ack_q;
    logic             err_q;

    logic             chip_busy;
    logic             aux_owns_bus;
    logic             aux_start;
    logic [15:0]      read_word;
    logic [3:0]       retry_inc;

    assign chip_busy    = chip_cs | chip_refresh;
    assign aux_owns_bus = (state == ST_AUX) & ~chip_busy;
    assign aux_start    = aux.aux_req & slot_free & ~chip_busy;

    // When DATA_LAT is the last cycle the word arrives on the same edge that
    // enters ACK, so it has to bypass the shadow register.
    assign read_word    = (cnt == CNT_DATA) ? sd_dout : dout_shadow;

    // Saturates so a requester that keeps retrying cannot wrap aux_err away.
    assign retry_inc    = (retry == 4'hF) ? retry : retry + 4'd1;

    assign aux.aux_ack  = ack_q;
    assign aux.aux_dout = dout_q;
    assign aux.aux_err  = err_q;

    // SDRAM port mux. The chipset override is combinational so a collision
    // hands the bus back in the very cycle chip_cs/chip_refresh rises.
    always_comb begin
        // NOTE: every output gets a default before the override; leaving one
        // unassigned on some path would infer a latch.
        sd_cs      = chip_cs;
        sd_we      = chip_we;
        sd_ds      = chip_ds;
        sd_addr    = chip_addr;
        sd_din     = chip_din;
        sd_refresh = chip_refresh;
        if (aux_owns_bus) begin
            sd_cs      = 1'b1;
            sd_we      = lat_we;
            sd_ds      = lat_ds;
            sd_addr    = lat_addr;
            sd_din     = lat_din;
            sd_refresh = 1'b0;
        end
    end

    always_ff @(posedge clk32 or negedge atari_reset_n) begin
        // NOTE: the command latch and data registers are cleared too; they are
        // a handful of flops, not a memory, and a defined value keeps sd_*
        // quiet until the first aux cycle.
        if (!atari_reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            retry       <= '0;
            lat_we      <= 1'b0;
            lat_ds      <= '0;
            lat_addr    <= '0;
            lat_din     <= '0;
            dout_shadow <= '0;
            dout_q      <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            collisions  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the register values from before this edge.
            ack_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // Chipset wins a tie: aux_start already excludes chip_busy.
                    if (aux_start) begin
                        state    <= ST_AUX;
                        cnt      <= '0;
                        lat_we   <= aux.aux_we;
                        lat_ds   <= aux.aux_ds;
                        lat_addr <= aux.aux_addr;
                        lat_din  <= aux.aux_din;
                    end
                end

                ST_AUX: begin
                    if (chip_busy) begin
                        // Abort; a still-pending aux_req restarts at the next free slot.
                        state <= ST_IDLE;
                        retry <= retry_inc;
                        if (retry_inc >= RETRY_LIMIT) begin
                            err_q <= 1'b1;
                        end
                        if (collisions != 8'hFF) begin
                            collisions <= collisions + 8'd1;
                        end
                    end else begin
                        if (!lat_we && cnt == CNT_DATA) begin
                            dout_shadow <= sd_dout;
                        end
                        if (cnt == CNT_LAST) begin
                            state <= ST_ACK;
                            ack_q <= 1'b1;
                            retry <= '0;
                            err_q <= 1'b0;
                            // Writes leave the last read word visible.
                            if (!lat_we) begin
                                dout_q <= read_word;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                ST_ACK: begin
                    // One dead cycle: a new request is taken from the next cycle on.
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
